bit_serial_adder: RTL and testbench

- Sequential bit-serial adder built around a single full-adder cell and a carry flip-flop.
- Computes A + B + cin one bit per clock, LSB first, and returns an N-bit sum and a carry-out.
- Inverse datapath of the team's full subtractor: reconstructs a minuend from difference plus subtrahend.
- Used where a narrow, low-area adder suffices and multi-cycle latency is acceptable.

---
 rtl/bit_serial_pkg.sv | 16 +
 rtl/full_add.sv | 13 +
 rtl/bit_serial_adder.sv | 95 +++++++++
 tb/tb_bit_serial_adder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// bit-counter sizing.
package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold 0..width-1 with one bit of headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_add.sv
// One-bit full adder cell; the addition counterpart of the full_sub cell.
module full_add (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop compute
// a + b + cin LSB first, one bit per clock, then present sum/cout until the next completion.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic             ready, accept, last_bit;
  logic             bit_s, bit_c;

  full_add u_full_add (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry),
    .s    (bit_s),
    .cout (bit_c)
  );

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    next_state = state;
    ready      = (state == IDLE) || (state == DONE);
    accept     = ready && start;
    last_bit   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    unique case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the FSM because a reset
  // must also wipe a previously held result, not just stop the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, regardless of statement order.
      state <= next_state;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        s_sh  <= {bit_s, s_sh[WIDTH-1:1]};
        carry <= bit_c;
        cnt   <= cnt + CW'(1);
        // Publish only the completed word so outputs never show partial sums.
        if (last_bit) begin
          sum_q  <= {bit_s, s_sh[WIDTH-1:1]};
          cout_q <= bit_c;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder: reset, carries/wrap, ignored start,
// back-to-back, mid-run reset and a full_sub round trip over random operands.
module tb_bit_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accepting edge, then scramble them during RUN.
  task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    start = 1'b1;
    a     = va;
    b     = vb;
    cin   = vc;
    tick();
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    cin   = 1'($urandom);
  endtask

  // Follow a run to its done cycle, checking the held result and busy length.
  task automatic wait_run(input string tag, input logic [WIDTH-1:0] held_sum, input logic held_cout);
    int n;
    n = 0;
    while (busy && n < WIDTH + 4) begin
      check({tag, "_held_sum"}, 32'(sum), 32'(held_sum));
      check({tag, "_held_cout"}, 32'(cout), 32'(held_cout));
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(WIDTH));
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Reference ripple-borrow subtractor built from full_sub cells.
  function automatic logic [WIDTH-1:0] full_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] d;
    logic             bw;
    bw = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      d[i] = x[i] ^ y[i] ^ bw;
      bw   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw);
    end
    return d;
  endfunction

  initial begin
    int               ndone;
    logic [WIDTH-1:0] seen_sum;
    logic [WIDTH-1:0] va, vb, vd;
    logic [WIDTH:0]   golden;
    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;

    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    cin   = 1'b1;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Basic add
    launch(8'h5A, 8'h33, 1'b0);
    wait_run("basic", 8'h00, 1'b0);
    check("basic_sum", 32'(sum), 32'h8D);
    check("basic_cout", 32'(cout), 32'd0);
    tick();
    check("basic_done_pulse", 32'(done), 32'd0);
    check("basic_idle_busy", 32'(busy), 32'd0);
    check("basic_sum_hold", 32'(sum), 32'h8D);

    // Wrap and carries
    launch(8'hFF, 8'h01, 1'b0);
    wait_run("wrap", 8'h8D, 1'b0);
    check("wrap_sum", 32'(sum), 32'h00);
    check("wrap_cout", 32'(cout), 32'd1);
    tick();
    launch(8'hFF, 8'hFF, 1'b1);
    wait_run("allones", 8'h00, 1'b1);
    check("allones_sum", 32'(sum), 32'hFF);
    check("allones_cout", 32'(cout), 32'd1);
    tick();

    // Start during RUN is ignored
    launch(8'h5A, 8'h33, 1'b0);
    tick();
    tick();
    start = 1'b1;
    a     = 8'h11;
    tick();
    start    = 1'b0;
    ndone    = 0;
    seen_sum = '0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        ndone++;
        seen_sum = sum;
      end
      tick();
    end
    check("ignored_done_count", 32'(ndone), 32'd1);
    check("ignored_sum", 32'(seen_sum), 32'h8D);
    check("ignored_idle", 32'(busy), 32'd0);

    // Back-to-back: new start during the done cycle
    launch(8'h5A, 8'h33, 1'b0);
    wait_run("b2b_first", 8'h8D, 1'b0);
    check("b2b_first_sum", 32'(sum), 32'h8D);
    launch(8'h10, 8'h20, 1'b0);
    check("b2b_busy_next", 32'(busy), 32'd1);
    wait_run("b2b_second", 8'h8D, 1'b0);
    check("b2b_second_sum", 32'(sum), 32'h30);
    check("b2b_second_cout", 32'(cout), 32'd0);
    tick();

    // Reset in the middle of a run
    launch(8'h5A, 8'h33, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) ndone++;
      tick();
    end
    check("midrst_quiet", 32'(ndone), 32'd0);
    launch(8'h12, 8'h34, 1'b1);
    wait_run("after_rst", 8'h00, 1'b0);
    check("after_rst_sum", 32'(sum), 32'h47);
    check("after_rst_cout", 32'(cout), 32'd0);
    tick();

    // Round trip against the full_sub reference
    prev_sum  = 8'h47;
    prev_cout = 1'b0;
    for (int r = 0; r < 200; r++) begin
      va     = WIDTH'($urandom);
      vb     = WIDTH'($urandom);
      vd     = full_sub(va, vb);
      golden = {1'b0, vd} + {1'b0, vb};
      launch(vd, vb, 1'b0);
      wait_run("rt", prev_sum, prev_cout);
      check("rt_sum", 32'(sum), 32'(va));
      check("rt_cout", 32'(cout), 32'(golden[WIDTH]));
      prev_sum  = va;
      prev_cout = golden[WIDTH];
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
